// File: rtl/instr_fetch.sv
// Instruction fetch unit: owns the PC, issues one instruction-memory read at a time,
// and hands the returned word to decode over a valid/ready handshake.
module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] pc,
    input  logic        branch_taken,
    input  logic [31:0] branch_offset,
    input  logic        jump,
    input  logic [25:0] jump_target,
    output logic [31:0] link_addr,
    output logic [31:0] retired_count
);

    localparam logic [1:0] S_RESET = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_VALID = 2'd3;

    localparam logic [31:0] PC_INIT = {RESET_PC[31:2], 2'b00};

    logic [1:0]  r_state;
    logic [31:0] r_pc;
    logic [31:0] r_instr;
    logic [31:0] r_link_addr;
    logic [31:0] r_retired_count;

    logic        w_accept;
    logic [31:0] w_pc_plus4;
    logic [31:0] w_branch_target;
    logic [31:0] w_jump_target;
    logic [31:0] w_npc;

    assign w_accept        = (r_state == S_VALID) && instr_ready;
    assign w_pc_plus4      = r_pc + 32'd4;
    assign w_branch_target = w_pc_plus4 + (branch_offset << 2);
    assign w_jump_target   = {w_pc_plus4[31:28], jump_target, 2'b00};

    // Branch outranks jump when decode raises both.
    always_comb begin
        w_npc = w_pc_plus4;
        if (branch_taken) begin
            w_npc = w_branch_target;
        end else if (jump) begin
            w_npc = w_jump_target;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_RESET;
        end else begin
            case (r_state)
                S_RESET: r_state <= S_FETCH;
                S_FETCH: r_state <= S_WAIT;
                S_WAIT:  if (imem_rvalid) r_state <= S_VALID;
                S_VALID: if (instr_ready) r_state <= S_FETCH;
                default: r_state <= S_RESET;
            endcase
        end
    end

    // Read data is captured only while a request is outstanding; stray beats are dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_instr <= 32'd0;
        end else if ((r_state == S_WAIT) && imem_rvalid) begin
            r_instr <= imem_rdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc            <= PC_INIT;
            r_link_addr     <= 32'd0;
            r_retired_count <= 32'd0;
        end else if (w_accept) begin
            r_pc            <= w_npc;
            r_link_addr     <= w_pc_plus4;
            r_retired_count <= r_retired_count + 32'd1;
        end
    end

    assign imem_req      = (r_state == S_FETCH);
    assign imem_addr     = r_pc;
    assign instr         = r_instr;
    assign instr_valid   = (r_state == S_VALID);
    assign pc            = r_pc;
    assign link_addr     = r_link_addr;
    assign retired_count = r_retired_count;

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch unit for the single-cycle/multicycle MIPS datapath. It owns the program counter, issues one word read at a time to instruction memory, and presents the returned 32-bit instruction to the control unit and register file with a valid/ready handshake. When the consumer accepts an instruction, it applies that instruction's branch/jump redirect, which produces the next PC and the `jal` link value for `$ra`.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_0000, first fetch address; bits [1:0] are forced to 0.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `imem_req` out 1: one-cycle read request pulse.
- `imem_addr` out 32: word-aligned fetch address, stable from req until rvalid.
- `imem_rvalid` in 1: read data valid, at the earliest 1 cycle after `imem_req`.
- `imem_rdata` in 32: instruction word, sampled when `imem_rvalid`=1.
- `instr` out 32: instruction presented to decode.
- `instr_valid` out 1: `instr` is valid.
- `instr_ready` in 1: consumer accepts `instr` this cycle.
- `pc` out 32: address of the current `instr`.
- `branch_taken` in 1: Branch AND ALU zero for the instruction being accepted.
- `branch_offset` in 32: sign-extended immediate, in words.
- `jump` in 1: Jump control for the instruction being accepted.
- `jump_target` in 26: instr[25:0] of the jump.
- `link_addr` out 32: pc+4 of the last accepted instruction, for writing `$ra` on `jal`.
- `retired_count` out 32: number of accepted instructions.

## Operation
- States:
  - RESET: entered asynchronously whenever `rst_n`=0.
  - FETCH: drives `imem_req`=1 for exactly one cycle, then goes to WAIT.
  - WAIT: waits for `imem_rvalid`. On rvalid, latch `imem_rdata` into `instr` and go to VALID.
  - VALID: holds `instr_valid`=1 and `instr`/`pc` stable. Stays in VALID while `instr_ready`=0.
- On accept (VALID and `instr_ready`=1), compute `npc`:
  - `branch_taken`=1: `npc` = pc+4+(branch_offset<<2), mod 2^32.
  - else `jump`=1: `npc` = {pc_plus4[31:28], jump_target, 2'b00}.
  - else: `npc` = pc+4.
  - `branch_taken` has priority over `jump` when both are set.
- Also on accept:
  - `link_addr` <= pc+4.
  - `retired_count` increments and wraps 2^32-1 -> 0.
  - `pc` and `imem_addr` <= `npc`.
  - State goes to FETCH.
- Redirect inputs are sampled only on the accept cycle and ignored otherwise.
- `imem_rvalid` outside WAIT is ignored. `imem_rdata` is never latched outside WAIT.
- Only one request is outstanding at any time. No flush logic exists, because a redirect is known before the next request is issued.
- All address arithmetic is 32-bit unsigned and wraps. The PC wraps 32'hFFFF_FFFC -> 0.

## Timing
- Values during reset:
  - `pc` and `imem_addr` = `RESET_PC`.
  - `imem_req`, `instr_valid`, `instr`, `link_addr` and `retired_count` = 0.
  - State = RESET.
- First rising edge with `rst_n`=1: RESET -> FETCH. `imem_req`=1 is visible in that following cycle.
- Cycle sequence:
  - Cycle n: `imem_req`=1.
  - Cycle n+k (k≥1): `imem_rvalid`=1.
  - Cycle n+k+1: `instr_valid`=1.
  - Accept in cycle m: `imem_req` for `npc` occurs in cycle m+1.
- Minimum period is 3 cycles per instruction, with zero-wait memory and `instr_ready` held at 1.
- `instr_valid` is registered and does not depend combinationally on `instr_ready`.
- Reset mid-WAIT or mid-VALID: all outputs return to their reset values immediately. The instruction in flight is dropped and the old request is abandoned. Instruction memory shares `rst_n`, so no stale rvalid arrives after release.

## Test plan
- **Reset/first fetch:** RESET_PC=0x0040_0000; release reset, memory responds 1 cycle later with 0x8C08_0004 -> `imem_addr`=0x0040_0000 with one `imem_req` pulse. Then `instr`=0x8C08_0004 with `instr_valid`=1, and `pc`=0x0040_0000.
- **Sequential + backpressure:** hold `instr_ready`=0 for 5 cycles, then assert it -> `instr` and `pc` stay stable and no `imem_req` occurs while stalled. Next request goes to 0x0040_0004, and `retired_count`=1.
- **Branch:** pc=0x100, `branch_taken`=1, offset=-2 (0xFFFF_FFFE) on accept -> next `imem_addr`=0x0FC. Same accept with offset=+3 -> 0x110.
- **Jump/jal:** pc=0x1000_0008, `jump`=1, target=0x0000040 -> next address 0x1000_0100, and `link_addr`=0x1000_000C.
- **Priority and stray data:** `branch_taken`=1 and `jump`=1 together -> branch target is taken. Pulse `imem_rvalid` with 0xDEAD_BEEF while in VALID -> `instr` is unchanged.
- **Reset mid-operation and wrap:** drop `rst_n` during WAIT -> outputs show reset values in the same cycle. Accept at pc=0xFFFF_FFFC with no redirect -> next address 0. Preload `retired_count`=0xFFFF_FFFF (or force it), then accept -> count becomes 0.
